nav_fsm_param: RTL and testbench

- Parametrised successor to the robot navigation controller.
- Drives the 4-bit motion-state code consumed by the motor driver from four edge (line) sensors, the ultrasonic target bit and the on switch.
- New over the previous generation: async reset, input synchronisation and debounce, a timed REVERSE escape manoeuvre, and a search sweep that alternates direction on timeout.
- Sits between the sensor front-end and the motor driver.

---
 rtl/nav_pkg.sv | 22 ++
 rtl/sensor_filter.sv | 46 ++++
 rtl/nav_fsm_param.sv | 120 ++++++++++++
 tb/tb_nav_fsm_param.sv | 357 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nav_pkg.sv
// rtl/nav_pkg.sv - motion-state codes shared by the navigation controller and the motor driver
package nav_pkg;

  localparam int STATE_W = 4;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE    = 4'd0,
    ST_RIGHT   = 4'd1,
    ST_LEFT    = 4'd2,
    ST_FORWARD = 4'd3,
    ST_SETUP   = 4'd4,
    ST_REVERSE = 4'd5,
    ST_OFF     = 4'd8
  } state_e;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/sensor_filter.sv
// rtl/sensor_filter.sv - 2-flop synchroniser plus stability filter for one asynchronous input bit
module sensor_filter #(
  parameter int FILT_LEN = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout
);

  localparam int CW = $clog2(FILT_LEN + 1);

  logic          meta_q, sync_q;
  logic          filt_q, filt_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Counter only runs while the synced bit disagrees with the filtered bit.
  always_comb begin
    filt_d = filt_q;
    cnt_d  = '0;
    if (sync_q != filt_q) begin
      if (cnt_q == CW'(FILT_LEN - 1)) begin
        filt_d = sync_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      filt_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      meta_q <= din;
      sync_q <= meta_q;
      filt_q <= filt_d;
      cnt_q  <= cnt_d;
    end
  end

  assign dout = filt_q;

endmodule

// File: rtl/nav_fsm_param.sv
// rtl/nav_fsm_param.sv - robot navigation FSM: filtered sensors, timed reverse escape, alternating search sweep
module nav_fsm_param
  import nav_pkg::*;
#(
  parameter int START_DELAY    = 1000000,
  parameter int FILT_LEN       = 4,
  parameter int REV_CYCLES     = 200000,
  parameter int SEARCH_TIMEOUT = 2000000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               on,
  input  logic               LF,
  input  logic               RF,
  input  logic               LB,
  input  logic               RB,
  input  logic               U,
  output logic [STATE_W-1:0] estado,
  output logic               dir,
  output logic               flip
);

  localparam int TMAX = max3(START_DELAY, REV_CYCLES, SEARCH_TIMEOUT);
  localparam int TW   = $clog2(TMAX) + 1;

  logic [5:0] raw, filt;
  logic       on_f, lf_f, rf_f, u_f, front, back;

  assign raw = {U, RB, LB, RF, LF, on};

  for (genvar i = 0; i < 6; i++) begin : g_filt
    sensor_filter #(.FILT_LEN(FILT_LEN)) u_filt (
      .clk (clk),
      .rst (rst),
      .din (raw[i]),
      .dout(filt[i])
    );
  end

  assign on_f  = filt[0];
  assign lf_f  = filt[1];
  assign rf_f  = filt[2];
  assign u_f   = filt[5];
  assign front = filt[1] | filt[2];
  assign back  = filt[3] | filt[4];

  state_e        st_q, st_d;
  logic [TW-1:0] tmr_q, tmr_d;
  logic          dir_q, dir_d;
  logic          flip_q, flip_d;

  always_comb begin
    st_d   = st_q;
    tmr_d  = tmr_q;
    dir_d  = dir_q;
    flip_d = 1'b0;
    if (st_q != ST_OFF && !on_f) begin
      st_d = ST_OFF;
    end else begin
      case (st_q)
        ST_OFF: if (on_f) st_d = ST_SETUP;
        ST_SETUP: begin
          if (tmr_q == TW'(START_DELAY - 1)) st_d = ST_IDLE;
          else tmr_d = tmr_q + 1'b1;
        end
        ST_IDLE: begin
          if (front)    st_d = ST_REVERSE;
          else if (u_f) st_d = ST_FORWARD;
          else          st_d = dir_q ? ST_LEFT : ST_RIGHT;
        end
        ST_FORWARD: begin
          if (front)     st_d = ST_REVERSE;
          else if (!u_f) st_d = ST_IDLE;
        end
        ST_REVERSE: begin
          if (back || tmr_q == TW'(REV_CYCLES - 1)) st_d = ST_IDLE;
          else tmr_d = tmr_q + 1'b1;
        end
        ST_RIGHT, ST_LEFT: begin
          if (front)    st_d = ST_REVERSE;
          else if (u_f) st_d = ST_FORWARD;
          else if (tmr_q == TW'(SEARCH_TIMEOUT - 1)) begin
            st_d   = (st_q == ST_RIGHT) ? ST_LEFT : ST_RIGHT;
            dir_d  = !dir_q;
            flip_d = 1'b1;
          end else begin
            tmr_d = tmr_q + 1'b1;
          end
        end
        default: st_d = ST_OFF;
      endcase
    end
    // Escape direction: turn away from the side that saw the edge.
    if (st_d == ST_REVERSE && st_q != ST_REVERSE) begin
      if (rf_f && !lf_f)      dir_d = 1'b1;
      else if (lf_f && !rf_f) dir_d = 1'b0;
      else if (lf_f && rf_f)  dir_d = !dir_q;
    end
    if (st_d != st_q) tmr_d = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q   <= ST_OFF;
      tmr_q  <= '0;
      dir_q  <= 1'b0;
      flip_q <= 1'b0;
    end else begin
      st_q   <= st_d;
      tmr_q  <= tmr_d;
      dir_q  <= dir_d;
      flip_q <= flip_d;
    end
  end

  assign estado = st_q;
  assign dir    = dir_q;
  assign flip   = flip_q;

endmodule

// File: tb/tb_nav_fsm_param.sv
// tb/tb_nav_fsm_param.sv - directed scenarios plus randomized run against a behavioural model
module tb_nav_fsm_param;

  localparam int START_DELAY    = 16;
  localparam int FILT_LEN       = 3;
  localparam int REV_CYCLES     = 8;
  localparam int SEARCH_TIMEOUT = 20;

  localparam logic [3:0] S_IDLE = 4'd0, S_RIGHT = 4'd1, S_LEFT = 4'd2, S_FWD = 4'd3,
                         S_SETUP = 4'd4, S_REV = 4'd5, S_OFF = 4'd8;

  logic       clk, rst, on, LF, RF, LB, RB, U;
  logic [3:0] estado;
  logic       dir, flip;

  int n_cmp = 0;
  int n_err = 0;

  nav_fsm_param #(
    .START_DELAY(START_DELAY), .FILT_LEN(FILT_LEN),
    .REV_CYCLES(REV_CYCLES), .SEARCH_TIMEOUT(SEARCH_TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst), .on(on), .LF(LF), .RF(RF), .LB(LB), .RB(RB), .U(U),
    .estado(estado), .dir(dir), .flip(flip)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: inputs seen two edges late, a bit changes after FILT_LEN
  // consecutive disagreeing samples, and each state is left after a number of
  // cycles spent in it.
  typedef struct packed {
    logic [3:0]  st;
    logic [31:0] t;
    logic        d;
    logic        f;
  } m_next_t;

  logic [5:0] raw_in;
  logic [5:0] m_d1, m_d2, m_filt;
  int         m_run [6];
  logic [3:0] m_state;
  int         m_time;
  logic       m_dir, m_flip;
  m_next_t    m_nx;

  assign raw_in = {U, RB, LB, RF, LF, on};

  function automatic m_next_t model_fsm(input logic [3:0] st, input int t, input logic d,
                                        input logic [5:0] f);
    m_next_t r;
    logic    run_on, front, back, u;
    run_on = f[0];
    front  = f[1] | f[2];
    back   = f[3] | f[4];
    u      = f[5];
    r.st = st;
    r.t  = t + 1;
    r.d  = d;
    r.f  = 1'b0;
    if (st == S_OFF) begin
      if (run_on) r.st = S_SETUP;
    end else if (!run_on) begin
      r.st = S_OFF;
    end else if (st == S_SETUP) begin
      if (t + 1 == START_DELAY) r.st = S_IDLE;
    end else if (st == S_IDLE) begin
      r.st = front ? S_REV : (u ? S_FWD : (d ? S_LEFT : S_RIGHT));
    end else if (st == S_FWD) begin
      if (front) r.st = S_REV;
      else if (!u) r.st = S_IDLE;
    end else if (st == S_REV) begin
      if (back || t + 1 == REV_CYCLES) r.st = S_IDLE;
    end else if (st == S_RIGHT || st == S_LEFT) begin
      if (front) r.st = S_REV;
      else if (u) r.st = S_FWD;
      else if (t + 1 == SEARCH_TIMEOUT) begin
        r.st = (st == S_RIGHT) ? S_LEFT : S_RIGHT;
        r.d  = !d;
        r.f  = 1'b1;
      end
    end else begin
      r.st = S_OFF;
    end
    if (r.st == S_REV && st != S_REV) begin
      if (f[2] && !f[1]) r.d = 1'b1;
      else if (f[1] && !f[2]) r.d = 1'b0;
      else if (f[1] && f[2]) r.d = !d;
    end
    if (r.st != st) r.t = 0;
    return r;
  endfunction

  assign m_nx = model_fsm(m_state, m_time, m_dir, m_filt);

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_d1    <= '0;
      m_d2    <= '0;
      m_filt  <= '0;
      for (int i = 0; i < 6; i++) m_run[i] <= 0;
      m_state <= S_OFF;
      m_time  <= 0;
      m_dir   <= 1'b0;
      m_flip  <= 1'b0;
    end else begin
      m_d1 <= raw_in;
      m_d2 <= m_d1;
      for (int i = 0; i < 6; i++) begin
        if (m_d2[i] == m_filt[i]) m_run[i] <= 0;
        else if (m_run[i] + 1 >= FILT_LEN) begin
          m_filt[i] <= m_d2[i];
          m_run[i]  <= 0;
        end else m_run[i] <= m_run[i] + 1;
      end
      m_state <= m_nx.st;
      m_time  <= int'(m_nx.t);
      m_dir   <= m_nx.d;
      m_flip  <= m_nx.f;
    end
  end

  task automatic test_reset;
    rst = 1'b0; on = 1'b0; LF = 1'b0; RF = 1'b0; LB = 1'b0; RB = 1'b0; U = 1'b0;
    #1 rst = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({estado, dir, flip} !== {S_OFF, 1'b0, 1'b0}) begin
      n_err++;
      $display("FAIL reset: estado=%0d dir=%0d flip=%0d, expected 8 0 0", estado, dir, flip);
    end
    rst = 1'b0;
  endtask

  task automatic test_startup_sweep;
    logic [3:0] es;
    logic       ed, ef;
    on = 1'b1;
    for (int k = 1; k <= 23; k++) begin
      @(negedge clk);
      es = (k <= 5) ? S_OFF : (k <= 21) ? S_SETUP : (k == 22) ? S_IDLE : S_RIGHT;
      n_cmp++;
      if ({estado, dir, flip} !== {es, 1'b0, 1'b0}) begin
        n_err++;
        $display("FAIL startup k=%0d: estado=%0d dir=%0d flip=%0d, expected %0d 0 0",
                 k, estado, dir, flip, es);
      end
    end
    for (int k = 1; k <= 41; k++) begin
      @(negedge clk);
      es = (k < 20 || k >= 40) ? S_RIGHT : S_LEFT;
      ed = (k >= 20 && k < 40);
      ef = (k == 20 || k == 40);
      n_cmp++;
      if ({estado, dir, flip} !== {es, ed, ef}) begin
        n_err++;
        $display("FAIL sweep k=%0d: estado=%0d dir=%0d flip=%0d, expected %0d %0d %0d",
                 k, estado, dir, flip, es, ed, ef);
      end
    end
  endtask

  task automatic test_forward_u;
    logic [3:0] es;
    U = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      es = (k < 6) ? S_RIGHT : S_FWD;
      n_cmp++;
      if ({estado, dir, flip} !== {es, 1'b0, 1'b0}) begin
        n_err++;
        $display("FAIL u_rise k=%0d: estado=%0d dir=%0d flip=%0d, expected %0d 0 0",
                 k, estado, dir, flip, es);
      end
    end
    U = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      es = (k < 6) ? S_FWD : (k == 6) ? S_IDLE : S_RIGHT;
      n_cmp++;
      if ({estado, dir, flip} !== {es, 1'b0, 1'b0}) begin
        n_err++;
        $display("FAIL u_fall k=%0d: estado=%0d dir=%0d flip=%0d, expected %0d 0 0",
                 k, estado, dir, flip, es);
      end
    end
  endtask

  task automatic test_glitch_and_reverse;
    logic [3:0] es;
    logic       ed;
    U = 1'b1;
    repeat (6) @(negedge clk);
    RF = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (k == 2) RF = 1'b0;
      n_cmp++;
      if (estado !== S_FWD) begin
        n_err++;
        $display("FAIL glitch k=%0d: estado=%0d, expected 3", k, estado);
      end
    end
    RF = 1'b1;
    for (int k = 1; k <= 15; k++) begin
      @(negedge clk);
      es = (k < 6) ? S_FWD : (k < 14) ? S_REV : (k == 14) ? S_IDLE : S_LEFT;
      ed = (k >= 6);
      n_cmp++;
      if ({estado, dir, flip} !== {es, ed, 1'b0}) begin
        n_err++;
        $display("FAIL reverse k=%0d: estado=%0d dir=%0d flip=%0d, expected %0d %0d 0",
                 k, estado, dir, flip, es, ed);
      end
      if (k == 6) begin
        RF = 1'b0;
        U  = 1'b0;
      end
    end
  endtask

  task automatic test_reverse_abort;
    logic [3:0] es;
    logic       ed;
    LF = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      es = (k < 6) ? S_LEFT : (k < 9) ? S_REV : (k == 9) ? S_IDLE : S_RIGHT;
      ed = (k < 6);
      n_cmp++;
      if ({estado, dir, flip} !== {es, ed, 1'b0}) begin
        n_err++;
        $display("FAIL rev_abort k=%0d: estado=%0d dir=%0d flip=%0d, expected %0d %0d 0",
                 k, estado, dir, flip, es, ed);
      end
      if (k == 3) begin
        LF = 1'b0;
        LB = 1'b1;
      end
    end
    LB = 1'b0;
  endtask

  task automatic test_off;
    logic [3:0] es;
    U = 1'b1;
    repeat (6) @(negedge clk);
    on = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      es = (k < 6) ? S_FWD : S_OFF;
      n_cmp++;
      if ({estado, flip} !== {es, 1'b0}) begin
        n_err++;
        $display("FAIL off k=%0d: estado=%0d flip=%0d, expected %0d 0", k, estado, flip, es);
      end
    end
    U = 1'b0;
  endtask

  task automatic test_off_vs_timeout;
    logic       found;
    logic [3:0] es;
    found = 1'b0;
    on = 1'b1;
    for (int k = 0; k < 200 && !found; k++) begin
      @(negedge clk);
      found = (flip === 1'b1);
    end
    n_cmp++;
    if (!found || estado !== S_LEFT) begin
      n_err++;
      $display("FAIL off_timeout_wait: found=%0d estado=%0d, expected 1 2", found, estado);
    end else begin
      for (int k = 1; k <= 20; k++) begin
        @(negedge clk);
        es = (k < 20) ? S_LEFT : S_OFF;
        n_cmp++;
        if ({estado, dir, flip} !== {es, 1'b1, 1'b0}) begin
          n_err++;
          $display("FAIL off_timeout k=%0d: estado=%0d dir=%0d flip=%0d, expected %0d 1 0",
                   k, estado, dir, flip, es);
        end
        if (k == 14) on = 1'b0;
      end
    end
  endtask

  task automatic test_async_reset;
    logic found;
    found = 1'b0;
    on = 1'b1;
    for (int k = 0; k < 100 && !found; k++) begin
      @(negedge clk);
      found = (estado === S_LEFT || estado === S_RIGHT);
    end
    RF = 1'b1;
    for (int k = 0; k < 20 && found && estado !== S_REV; k++) @(negedge clk);
    n_cmp++;
    if (!found || estado !== S_REV || dir !== 1'b1) begin
      n_err++;
      $display("FAIL areset_setup: found=%0d estado=%0d dir=%0d, expected 1 5 1", found, estado, dir);
    end
    #1 rst = 1'b1;
    #1;
    n_cmp++;
    if ({estado, dir, flip} !== {S_OFF, 1'b0, 1'b0}) begin
      n_err++;
      $display("FAIL areset: estado=%0d dir=%0d flip=%0d, expected 8 0 0", estado, dir, flip);
    end
    RF = 1'b0;
    on = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_random;
    int pick;
    on = 1'b1;
    for (int k = 0; k < 4000; k++) begin
      @(negedge clk);
      n_cmp++;
      if ({estado, dir, flip} !== {m_state, m_dir, m_flip}) begin
        n_err++;
        $display("FAIL random k=%0d: estado=%0d dir=%0d flip=%0d, expected %0d %0d %0d",
                 k, estado, dir, flip, m_state, m_dir, m_flip);
      end
      if ($urandom_range(0, 7) == 0) begin
        pick = $urandom_range(0, 5);
        case (pick)
          0: if (!on || $urandom_range(0, 9) == 0) on = !on;
          1: LF = !LF;
          2: RF = !RF;
          3: LB = !LB;
          4: RB = !RB;
          default: U = !U;
        endcase
      end
    end
  endtask

  initial begin
    test_reset();
    test_startup_sweep();
    test_forward_u();
    test_glitch_and_reverse();
    test_reverse_abort();
    test_off();
    test_off_vs_timeout();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
